lsu_ctrl: RTL and testbench

- Load/store sequencer between the core's execute stage and a handshaked data memory.
- Accepts one memory operation per request and checks alignment and size.
- Generates word-aligned address, byte enables and lane-replicated write data; holds the memory request until acknowledge.
- Returns sign/zero-extended load data and stalls the pipeline for the whole access.

---
 rtl/lsu_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the execute stage and a handshaked
// data memory. Checks size/alignment, issues one word-aligned memory request
// per op, holds it until acknowledge and returns sign/zero-extended load data.
// Optional macro LSU_TIMEOUT_EN: abort an access after TIMEOUT cycles without
// acknowledge and report a bus-timeout exception (cause 11).
module lsu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_vld,
    output logic        o_exc,
    output logic [1:0]  o_exc_cause,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;

    logic        size_ok;
    logic        align_ok;
    logic        legal;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("lsu_ctrl: TIMEOUT must be at least 1");
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt;
`endif

    // Decode legality of the presented op: size first, then alignment
    always_comb begin
        size_ok  = 1'b0;
        align_ok = 1'b1;
        case (i_funct3)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = !i_we;
            default:                size_ok = 1'b0;
        endcase
        case (i_funct3[1:0])
            2'b01:   align_ok = !i_addr[0];
            2'b10:   align_ok = (i_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        legal = size_ok && align_ok;
    end

    // Byte enables and lane-replicated store data for the request
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << i_addr[1:0];
                wdata_next = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{i_wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = i_wdata;
            end
        endcase
    end

    // Pick the addressed lane of the returned word and extend it
    always_comb begin
        case (lo_q)
            2'd0:    ld_byte = i_mem_rdata[7:0];
            2'd1:    ld_byte = i_mem_rdata[15:8];
            2'd2:    ld_byte = i_mem_rdata[23:16];
            default: ld_byte = i_mem_rdata[31:24];
        endcase
        ld_half = lo_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = i_mem_rdata;
        endcase
    end

    // Pipeline freeze: from a legal request in IDLE through the whole access
    assign o_stall = !i_reset &&
                     (((state == IDLE) && i_req && legal) || (state == ACCESS));

    // Sequencer FSM with registered memory, data and exception outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            lo_q        <= 2'd0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_be    <= 4'd0;
            o_mem_wdata <= 32'd0;
            o_rdata     <= 32'd0;
            o_rdata_vld <= 1'b0;
            o_exc       <= 1'b0;
            o_exc_cause <= 2'd0;
`ifdef LSU_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            o_exc       <= 1'b0;
            o_rdata_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        if (!size_ok) begin
                            o_exc       <= 1'b1;
                            o_exc_cause <= 2'b10;
                        end else if (!align_ok) begin
                            o_exc       <= 1'b1;
                            o_exc_cause <= 2'b01;
                        end else begin
                            we_q        <= i_we;
                            f3_q        <= i_funct3;
                            lo_q        <= i_addr[1:0];
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_we;
                            o_mem_addr  <= {i_addr[31:2], 2'b00};
                            o_mem_be    <= be_next;
                            o_mem_wdata <= wdata_next;
`ifdef LSU_TIMEOUT_EN
                            cnt         <= '0;
`endif
                            state       <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        if (!we_q) begin
                            o_rdata     <= ld_data;
                            o_rdata_vld <= 1'b1;
                        end
                        state <= DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_exc       <= 1'b1;
                        o_exc_cause <= 2'b11;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized scoreboard bench for lsu_ctrl. The driver pushes
// expected memory requests, load results and exceptions; a negedge monitor
// pops and compares whenever the DUT presents one of them.
module tb_lsu_ctrl;

    localparam int TO = 16;
    localparam int K_MEM = 0, K_RD = 1, K_EXC = 2;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wdata = 32'd0;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_rdata_vld;
    logic        o_exc;
    logic [1:0]  o_exc_cause;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = 32'd0;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_stall(o_stall), .o_rdata(o_rdata), .o_rdata_vld(o_rdata_vld),
        .o_exc(o_exc), .o_exc_cause(o_exc_cause), .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        we;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          stall_cnt = 0;
    logic [31:0] last_ld = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference rules: returns 0 for a legal op, else the exception cause
    function automatic int op_cause(input bit we, input bit [2:0] f3, input bit [31:0] addr);
        int nb;
        bit ok;
        ok = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!ok) return 2;
        nb = 1 << f3[1:0];
        if ((addr % nb) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] ld_model(input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] rd);
        int nb;
        longint unsigned mask, v;
        nb   = 1 << f3[1:0];
        mask = (64'd1 << (8 * nb)) - 1;
        v    = (longint'(rd) >> (8 * (addr % 4))) & mask;
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (~mask);
        return v[31:0];
    endfunction

    // Run one op: push expectations, drive request and memory ack
    task automatic do_op(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wd, input int lat, input bit [31:0] rd);
        int   c, nb, s0;
        exp_t e;
        c  = op_cause(we, f3, addr);
        s0 = stall_cnt;
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
        if (c != 0) begin
            e = '{kind: K_EXC, addr: 0, data: 32'(c), be: 0, we: 0};
            q.push_back(e);
            @(posedge i_clk); #1;
            i_req = 1'b0;
            @(posedge i_clk); #1;
            chk("exc_stall_cycles", 32'(stall_cnt - s0), 32'd0);
        end else begin
            nb = 1 << f3[1:0];
            e.kind = K_MEM;
            e.addr = addr & 32'hFFFF_FFFC;
            e.be   = 4'(((1 << nb) - 1) << (addr % 4));
            e.we   = we;
            e.data = (nb == 1) ? wd[7:0] * 32'h0101_0101 :
                     (nb == 2) ? wd[15:0] * 32'h0001_0001 : wd;
            q.push_back(e);
            if (!we) begin
                last_ld = ld_model(f3, addr, rd);
                e = '{kind: K_RD, addr: 0, data: last_ld, be: 0, we: 0};
                q.push_back(e);
            end
            @(posedge i_clk); #1;
            repeat (lat) @(posedge i_clk);
            if (lat > 0) #1;
            i_mem_ack = 1'b1; i_mem_rdata = rd;
            @(posedge i_clk); #1;
            i_mem_ack = 1'b0; i_mem_rdata = $urandom;
            if ($urandom_range(0, 1) == 0) i_req = 1'b0;
            @(posedge i_clk); #1;
            i_req = 1'b0;
            chk("op_stall_cycles", 32'(stall_cnt - s0), 32'(lat + 2));
            chk("rdata_hold", o_rdata, last_ld);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(o_mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(o_mem_we), 32'd0);
        chk({tag, "_mem_addr"}, o_mem_addr, 32'd0);
        chk({tag, "_mem_be"}, 32'(o_mem_be), 32'd0);
        chk({tag, "_mem_wdata"}, o_mem_wdata, 32'd0);
        chk({tag, "_rdata"}, o_rdata, 32'd0);
        chk({tag, "_rdata_vld"}, 32'(o_rdata_vld), 32'd0);
        chk({tag, "_exc"}, 32'(o_exc), 32'd0);
        chk({tag, "_exc_cause"}, 32'(o_exc_cause), 32'd0);
        chk({tag, "_stall"}, 32'(o_stall), 32'd0);
    endtask

    // Monitor: pop and compare whenever the DUT presents a response
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    always @(negedge i_clk) begin
        exp_t e;
        if (o_stall) stall_cnt++;
        if (!i_reset) begin
            if (o_mem_req && prev_req) begin
                chk("mem_addr_hold", o_mem_addr, prev_addr);
                chk("mem_wdata_hold", o_mem_wdata, prev_wdata);
            end
            if (o_exc && o_rdata_vld) chk("exc_and_vld", 32'd1, 32'd0);
            if (o_mem_req && i_mem_ack) begin
                if (q.size() == 0 || q[0].kind != K_MEM) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("mem_addr", o_mem_addr, e.addr);
                    chk("mem_be", 32'(o_mem_be), 32'(e.be));
                    chk("mem_we", 32'(o_mem_we), 32'(e.we));
                    if (e.we) chk("mem_wdata", o_mem_wdata, e.data);
                end
            end
            if (o_rdata_vld) begin
                if (q.size() == 0 || q[0].kind != K_RD) begin
                    chk("unexpected_rdata_vld", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rdata", o_rdata, e.data);
                end
            end
            if (o_exc) begin
                if (q.size() == 0 || q[0].kind != K_EXC) begin
                    chk("unexpected_exc", 32'(o_exc_cause), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("exc_cause", 32'(o_exc_cause), e.data);
                end
            end
        end
        prev_req   = o_mem_req;
        prev_addr  = o_mem_addr;
        prev_wdata = o_mem_wdata;
    end

    initial begin
        bit [2:0] f3;
        bit [31:0] a;
        // reset with a legal request present: stall must stay low
        i_req = 1'b1; i_funct3 = 3'b010; i_addr = 32'h100;
        repeat (3) @(posedge i_clk);
        #1;
        chk_all_zero("reset");
        i_req = 1'b0;
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        // directed cases
        do_op(1'b0, 3'b010, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
        do_op(1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h80FF_FF7F);
        do_op(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h80FF_FF7F);
        do_op(1'b0, 3'b001, 32'h0000_0102, 32'h0, 3, 32'h80FF_FF7F);
        do_op(1'b1, 3'b000, 32'h0000_0201, 32'h1234_5678, 0, 32'h0);
        do_op(1'b1, 3'b001, 32'h0000_0202, 32'hCAFE_BABE, 1, 32'h0);
        do_op(1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h0);
        do_op(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);
        do_op(1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 32'h0);
        do_op(1'b0, 3'b011, 32'h0000_0101, 32'h0, 0, 32'h0);
        do_op(1'b1, 3'b001, 32'h0000_0203, 32'h0, 0, 32'h0);

        // reset during ACCESS, then a late ack that must be ignored
        i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h300;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_req = 1'b0; i_reset = 1'b1;
        #1;
        chk("reset_stall", 32'(o_stall), 32'd0);
        @(posedge i_clk); #1;
        chk_all_zero("midreset");
        last_ld = 32'd0;
        i_reset = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_2222;
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        chk("late_ack_req", 32'(o_mem_req), 32'd0);
        chk("late_ack_vld", 32'(o_rdata_vld), 32'd0);
        @(posedge i_clk); #1;
        do_op(1'b0, 3'b010, 32'h0000_0300, 32'h0, 1, 32'h5A5A_A5A5);

`ifdef LSU_TIMEOUT_EN
        begin
            int n, s0;
            exp_t e;
            s0 = stall_cnt;
            e = '{kind: K_EXC, addr: 0, data: 32'd3, be: 0, we: 0};
            q.push_back(e);
            i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h400;
            @(posedge i_clk); #1;
            n = 0;
            while (o_mem_req && n < 40) begin
                @(posedge i_clk); #1;
                n++;
            end
            i_req = 1'b0;
            chk("timeout_access_cycles", 32'(n), 32'(TO));
            @(posedge i_clk); #1;
            chk("timeout_stall_cycles", 32'(stall_cnt - s0), 32'(TO + 1));
            chk("timeout_rdata_hold", o_rdata, last_ld);
        end
`endif

        // randomized ops
        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~(2'(1 << f3[1:0]) - 2'd1);
            do_op(1'($urandom_range(0, 1)), f3, a, $urandom,
                  $urandom_range(0, 4), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge i_clk); #1;
            end
        end

        repeat (3) @(posedge i_clk);
        #1;
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
